// File: rtl/crc_fcs_checker.sv
// Receive-side FCS checker: runs each packet (data + FCS) through a CRC engine, compares the
// final remainder against the residue, tags runts and queues one {runt, crc_ok} word per packet.
// Latency: status word visible one cycle after the engine result; consumer stalls via stat_ready.

// Generic synchronous FIFO with head-of-queue output.
// Latency: a pushed entry is visible at the head one cycle later.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// CRC-32 engine, MSB-first, one word per cycle, remainder reported per packet.
// Latency: crc_en_out pulses 1+GO_BACK_STAGE cycles after the eop word.
// Backpressure: none; accepts a word every cycle.
module c_xor_and_go_back #(
  parameter int MOD_WIDTH     = 12,
  parameter int GO_BACK_STAGE = 0,
  parameter int GO_BACK_POLY  = 0,
  parameter int C_POLY        = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dval_in,
  input  logic                 eop_in,
  input  logic [MOD_WIDTH-1:0] mod_in,
  input  logic [31:0]          din,
  output logic [31:0]          crc_out,
  output logic                 crc_en_out
);
  // Zero selects the Ethernet polynomial; a nonzero GO_BACK_POLY overrides the all-ones seed.
  localparam logic [31:0] POLY = (C_POLY == 0) ? 32'h04C11DB7 : 32'(C_POLY);
  localparam logic [31:0] SEED = (GO_BACK_POLY == 0) ? 32'hFFFFFFFF : 32'(GO_BACK_POLY);

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d,
                                           input logic [2:0] n);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int b = 0; b < 4; b++) begin
      if (b < int'(n)) begin
        for (int k = 0; k < 8; k++) begin
          fb = r[31] ^ d[31-8*b-k];
          r  = {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
      end
    end
    return r;
  endfunction

  logic [31:0]            crc_q;
  logic [31:0]            crc_nxt;
  logic [2:0]             nbytes;
  logic [31:0]            res_q [GO_BACK_STAGE+1];
  logic [GO_BACK_STAGE:0] en_q;

  // Valid bytes in this word: mod_in 1..3 on the last word, otherwise all four (leading bytes).
  always_comb begin
    nbytes = 3'd4;
    if (eop_in) begin
      if (mod_in == MOD_WIDTH'(1))      nbytes = 3'd1;
      else if (mod_in == MOD_WIDTH'(2)) nbytes = 3'd2;
      else if (mod_in == MOD_WIDTH'(3)) nbytes = 3'd3;
    end
    crc_nxt = crc_step(crc_q, din, nbytes);
  end

  // Running remainder, reseeded after each eop; result pipeline behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= SEED;
      en_q  <= '0;
      for (int k = 0; k <= GO_BACK_STAGE; k++) res_q[k] <= '0;
    end else begin
      if (dval_in) crc_q <= eop_in ? SEED : crc_nxt;
      en_q[0] <= dval_in & eop_in;
      if (dval_in & eop_in) res_q[0] <= crc_nxt;
      for (int k = 1; k <= GO_BACK_STAGE; k++) begin
        res_q[k] <= res_q[k-1];
        en_q[k]  <= en_q[k-1];
      end
    end
  end

  assign crc_out    = res_q[GO_BACK_STAGE];
  assign crc_en_out = en_q[GO_BACK_STAGE];
endmodule

// Top-level checker: word counting, runt tagging, result matching, status queue, statistics.
// Latency: status word one cycle after the engine result.
// Backpressure: stat_ready stalls the status FIFO; a full FIFO drops new results and counts them.
module crc_fcs_checker #(
  parameter int          MOD_WIDTH      = 12,
  parameter int          GO_BACK_STAGE  = 0,
  parameter int          GO_BACK_POLY   = 0,
  parameter int          C_POLY         = 0,
  parameter logic [31:0] RESIDUE        = 32'hC704DD7B,
  parameter int          MIN_WORDS      = 16,
  parameter int          INFLIGHT_DEPTH = 8,
  parameter int          STAT_DEPTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dval_in,
  input  logic                 eop_in,
  input  logic [MOD_WIDTH-1:0] mod_in,
  input  logic [31:0]          din,
  output logic                 stat_valid,
  input  logic                 stat_ready,
  output logic [1:0]           stat_data,
  input  logic                 cnt_clr,
  output logic [31:0]          good_cnt,
  output logic [31:0]          bad_cnt,
  output logic [15:0]          drop_cnt,
  output logic                 ovf_err,
  output logic                 proto_err
);
  localparam int WCW = $clog2(MIN_WORDS + 1);

  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic           runt_now;
  logic           tag_push_q, tag_dat_q;
  logic [31:0]    crc_out;
  logic           crc_en;
  logic           tag_full, tag_empty;
  logic [0:0]     tag_head;
  logic           tag_bypass;
  logic           res_runt, res_ok, res_good;
  logic           proto_evt;
  logic           stat_full, stat_empty, stat_pop, ovf_evt;
  logic [31:0]    good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;
  logic           ovf_err_q, ovf_err_d, proto_err_q, proto_err_d;

  // Words seen so far in the current packet, saturating at MIN_WORDS.
  always_comb begin
    word_cnt_d = word_cnt_q;
    if (dval_in) begin
      if (eop_in)                              word_cnt_d = '0;
      else if (32'(word_cnt_q) < MIN_WORDS)    word_cnt_d = word_cnt_q + WCW'(1);
    end
  end

  // Count includes the eop word itself.
  assign runt_now = (32'(word_cnt_q) + 32'd1) < 32'(MIN_WORDS);

  // Word counter and the one-cycle-delayed runt tag push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_q <= '0;
      tag_push_q <= 1'b0;
      tag_dat_q  <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      tag_push_q <= dval_in & eop_in;
      tag_dat_q  <= runt_now;
    end
  end

  c_xor_and_go_back #(
    .MOD_WIDTH     (MOD_WIDTH),
    .GO_BACK_STAGE (GO_BACK_STAGE),
    .GO_BACK_POLY  (GO_BACK_POLY),
    .C_POLY        (C_POLY)
  ) u_engine (
    .clk        (clk),
    .rst        (rst),
    .dval_in    (dval_in),
    .eop_in     (eop_in),
    .mod_in     (mod_in),
    .din        (din),
    .crc_out    (crc_out),
    .crc_en_out (crc_en)
  );

  // A fast engine can report in the same cycle the tag arrives at an empty queue: hand it
  // straight through instead of flagging a protocol error.
  assign tag_bypass = crc_en & tag_empty & tag_push_q;

  sync_fifo #(.WIDTH(1), .DEPTH(INFLIGHT_DEPTH)) u_tag_q (
    .clk        (clk),
    .rst        (rst),
    .push_i     (tag_push_q & ~tag_bypass),
    .push_dat_i (tag_dat_q),
    .pop_i      (crc_en),
    .full_o     (tag_full),
    .empty_o    (tag_empty),
    .head_o     (tag_head)
  );

  assign res_runt  = tag_bypass ? tag_dat_q : (tag_empty ? 1'b0 : tag_head[0]);
  assign res_ok    = (crc_out == RESIDUE);
  assign res_good  = res_ok & ~res_runt;
  assign proto_evt = (crc_en & tag_empty & ~tag_push_q) | (tag_push_q & tag_full & ~crc_en);

  assign stat_pop = stat_valid & stat_ready;
  assign ovf_evt  = crc_en & stat_full & ~stat_pop;

  sync_fifo #(.WIDTH(2), .DEPTH(STAT_DEPTH)) u_stat_q (
    .clk        (clk),
    .rst        (rst),
    .push_i     (crc_en),
    .push_dat_i ({res_runt, res_ok}),
    .pop_i      (stat_pop),
    .full_o     (stat_full),
    .empty_o    (stat_empty),
    .head_o     (stat_data)
  );

  assign stat_valid = ~stat_empty;

  // Saturating statistics and sticky flags; a clear overrides any same-cycle event.
  always_comb begin
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    ovf_err_d   = ovf_err_q;
    proto_err_d = proto_err_q;
    if (cnt_clr) begin
      good_cnt_d  = '0;
      bad_cnt_d   = '0;
      drop_cnt_d  = '0;
      ovf_err_d   = 1'b0;
      proto_err_d = 1'b0;
    end else begin
      if (crc_en) begin
        if (res_good && good_cnt_q != 32'hFFFFFFFF)  good_cnt_d = good_cnt_q + 32'd1;
        if (!res_good && bad_cnt_q != 32'hFFFFFFFF)  bad_cnt_d  = bad_cnt_q + 32'd1;
      end
      if (ovf_evt) begin
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        ovf_err_d = 1'b1;
      end
      if (proto_evt) proto_err_d = 1'b1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      ovf_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      ovf_err_q   <= ovf_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign good_cnt  = good_cnt_q;
  assign bad_cnt   = bad_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign ovf_err   = ovf_err_q;
  assign proto_err = proto_err_q;
endmodule

// File: tb/tb_crc_fcs_checker.sv
// Bench for crc_fcs_checker: table of packets plus hand-written overflow, burst and reset cases.
// Expected status words go to a queue at eop and are compared when the DUT hands them out.
// Consumer readiness is driven by the bench to exercise stalls and FIFO overflow.
module tb_crc_fcs_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dval_in = 1'b0;
  logic        eop_in = 1'b0;
  logic [11:0] mod_in = '0;
  logic [31:0] din = '0;
  logic        stat_valid;
  logic        stat_ready = 1'b1;
  logic [1:0]  stat_data;
  logic        cnt_clr = 1'b0;
  logic [31:0] good_cnt, bad_cnt;
  logic [15:0] drop_cnt;
  logic        ovf_err, proto_err;

  crc_fcs_checker dut (
    .clk        (clk),
    .rst        (rst),
    .dval_in    (dval_in),
    .eop_in     (eop_in),
    .mod_in     (mod_in),
    .din        (din),
    .stat_valid (stat_valid),
    .stat_ready (stat_ready),
    .stat_data  (stat_data),
    .cnt_clr    (cnt_clr),
    .good_cnt   (good_cnt),
    .bad_cnt    (bad_cnt),
    .drop_cnt   (drop_cnt),
    .ovf_err    (ovf_err),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         pops = 0;
  int         model_good = 0;
  int         model_bad = 0;
  logic [1:0] exp_q [$];
  logic [1:0] exp_m;

  typedef struct {
    int         nw;
    int         fw;
    int         fb;
    logic [1:0] exp_stat;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit-serial reference CRC over one full 32-bit word, MSB first.
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [31:0] w);
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ w[i]) c = (c << 1) ^ 32'h04C11DB7;
      else              c = c << 1;
    end
    return c;
  endfunction

  // Drive one packet of nw words (last word is the FCS); optionally flip bit fb of word fw.
  task automatic send_pkt(input int nw, input int fw, input int fb, input logic [1:0] exp,
                          input bit expect_it);
    logic [31:0] w [64];
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < nw - 1; i++) begin
      w[i] = $urandom;
      c    = ref_crc(c, w[i]);
    end
    w[nw-1] = ~c;
    if (fw >= 0) w[fw][fb] = ~w[fw][fb];
    if (exp == 2'b01) model_good++;
    else              model_bad++;
    for (int i = 0; i < nw; i++) begin
      @(posedge clk); #1;
      dval_in = 1'b1;
      din     = w[i];
      eop_in  = (i == nw - 1);
      mod_in  = 12'd4;
      if (eop_in && expect_it) exp_q.push_back(exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      dval_in = 1'b0;
      eop_in  = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    model_good = 0;
    model_bad  = 0;
    @(negedge clk);
  endtask

  // Scoreboard: compare every status word the consumer accepts.
  always @(negedge clk) begin
    if (!rst && stat_valid && stat_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_status: got %0b expected none", stat_data);
      end else begin
        exp_m = exp_q.pop_front();
        chk("stat_data", 32'(stat_data), 32'(exp_m));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    vecs[0] = '{16, -1, 0,  2'b01};
    vecs[1] = '{16,  3, 5,  2'b00};
    vecs[2] = '{3,  -1, 0,  2'b11};
    vecs[3] = '{17, -1, 0,  2'b01};
    vecs[4] = '{15, -1, 0,  2'b11};
    vecs[5] = '{1,  -1, 0,  2'b11};
    vecs[6] = '{20, 19, 0,  2'b00};
    vecs[7] = '{32, 10, 31, 2'b00};

    repeat (3) @(negedge clk);
    chk("rst_stat_valid", 32'(stat_valid), 32'd0);
    chk("rst_stat_data",  32'(stat_data),  32'd0);
    chk("rst_good",       good_cnt,        32'd0);
    chk("rst_bad",        bad_cnt,         32'd0);
    chk("rst_drop",       32'(drop_cnt),   32'd0);
    chk("rst_ovf",        32'(ovf_err),    32'd0);
    chk("rst_proto",      32'(proto_err),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Table of single packets, each drained and counted.
    for (int v = 0; v < 8; v++) begin
      send_pkt(vecs[v].nw, vecs[v].fw, vecs[v].fb, vecs[v].exp_stat, 1'b1);
      idle(1);
      wait_drain();
      chk("good_cnt", good_cnt, 32'(model_good));
      chk("bad_cnt",  bad_cnt,  32'(model_bad));
    end
    chk("proto_after_table", 32'(proto_err), 32'd0);
    chk("ovf_after_table",   32'(ovf_err),   32'd0);

    pulse_clr();
    chk("clr_good", good_cnt, 32'd0);
    chk("clr_bad",  bad_cnt,  32'd0);

    // Stalled consumer, nine good packets: eight stored, one dropped.
    @(posedge clk); #1;
    stat_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_pkt(16, -1, 0, 2'b01, i < 8);
    idle(1);
    repeat (20) @(negedge clk);
    chk("ovf_drop",       32'(drop_cnt),   32'd1);
    chk("ovf_flag",       32'(ovf_err),    32'd1);
    chk("ovf_good",       good_cnt,        32'd9);
    chk("ovf_stat_valid", 32'(stat_valid), 32'd1);
    chk("ovf_stat_hold",  32'(stat_data),  32'd1);
    p0 = pops;
    @(posedge clk); #1;
    stat_ready = 1'b1;
    wait_drain();
    chk("ovf_pops", 32'(pops - p0), 32'd8);
    chk("ovf_empty", 32'(stat_valid), 32'd0);
    pulse_clr();
    chk("clr_ovf",  32'(ovf_err),  32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);

    // Single-word packets back to back.
    p0 = pops;
    for (int i = 0; i < 20; i++) send_pkt(1, -1, 0, 2'b11, 1'b1);
    idle(1);
    wait_drain();
    chk("burst_pops",  32'(pops - p0),  32'd20);
    chk("burst_bad",   bad_cnt,         32'd20);
    chk("burst_proto", 32'(proto_err),  32'd0);

    // Reset in word 7 of a packet, then one clean packet.
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      dval_in = 1'b1;
      eop_in  = 1'b0;
      din     = $urandom;
      if (i == 6) rst = 1'b1;
    end
    @(negedge clk);
    chk("mid_rst_stat_valid", 32'(stat_valid), 32'd0);
    chk("mid_rst_good",       good_cnt,        32'd0);
    chk("mid_rst_bad",        bad_cnt,         32'd0);
    chk("mid_rst_proto",      32'(proto_err),  32'd0);
    model_good = 0;
    model_bad  = 0;
    @(posedge clk); #1;
    dval_in = 1'b0;
    rst     = 1'b0;
    idle(1);
    p0 = pops;
    send_pkt(16, -1, 0, 2'b01, 1'b1);
    idle(1);
    wait_drain();
    chk("post_rst_pops", 32'(pops - p0), 32'd1);
    chk("post_rst_good", good_cnt,       32'd1);
    chk("post_rst_bad",  bad_cnt,        32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
